// File: rtl/axil_macc_div_pkg.sv
// Shared constants and FSM state type for the MACC signed divider.
// No ports; imported by the divider top and its iteration step.
package axil_macc_div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W);

  localparam logic [DIV_W-1:0] DBZ_QUOT = {DIV_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/axil_macc_sdiv_step.sv
// One restoring-division iteration: shift in a dividend bit, trial subtract.
// Ports: prem/dvs/nbit in; rem_o (new partial remainder) and qbit out.
module axil_macc_sdiv_step
  import axil_macc_div_pkg::*;
#(
  parameter int W = DIV_W
) (
  input  logic [W-1:0] prem,
  input  logic [W-1:0] dvs,
  input  logic         nbit,
  output logic [W-1:0] rem_o,
  output logic         qbit
);

  logic [W:0] sh;

  // prem < dvs on entry, so sh < 2*dvs and the difference fits in W bits.
  assign sh    = {prem, nbit};
  assign qbit  = (sh >= {1'b0, dvs});
  assign rem_o = qbit ? W'(sh - {1'b0, dvs}) : sh[W-1:0];

endmodule

// File: rtl/axil_macc_sdiv_32s_32s_32_seq.sv
// Sequential signed divider, C semantics, one quotient bit per clock.
// Ports: ap_clk, ap_rst_n, in_valid/in_ready/din0/din1, out_valid/out_ready/quot/rem/dbz.
module axil_macc_sdiv_32s_32s_32_seq
  import axil_macc_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 32,
  parameter int din1_WIDTH = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] quot,
  output logic [dout_WIDTH-1:0] rem,
  output logic                  dbz
);

  localparam int W  = din0_WIDTH;
  localparam int CW = $clog2(W);

  if (dout_WIDTH != W || din1_WIDTH > W || ID < 0) begin : g_cfg_err
    $error("bad divider width configuration");
  end

  div_state_t    state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  dvd;
  logic [W-1:0]  dvs;
  logic [W-1:0]  prem;
  logic          neg_q;
  logic          neg_r;
  logic          zero_l;
  logic [W-1:0]  quot_q;
  logic [W-1:0]  rem_q;
  logic          dbz_q;

  logic signed [W-1:0] d1x;
  logic [W-1:0]        a0;
  logic [W-1:0]        a1;
  logic [W-1:0]        st_rem;
  logic                st_q;

  assign d1x = W'($signed(din1));
  // |MIN| = 2^(W-1) is representable as W-bit unsigned.
  assign a0  = din0[W-1] ? W'(-din0) : din0;
  assign a1  = d1x[W-1] ? W'(-d1x) : d1x;

  axil_macc_sdiv_step #(.W(W)) u_step (
    .prem  (prem),
    .dvs   (dvs),
    .nbit  (dvd[W-1]),
    .rem_o (st_rem),
    .qbit  (st_q)
  );

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      prem   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      zero_l <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dvd    <= a0;
            dvs    <= a1;
            prem   <= '0;
            neg_r  <= din0[W-1];
            neg_q  <= din0[W-1] ^ d1x[W-1];
            zero_l <= (din1 == '0);
            cnt    <= CW'(W - 1);
            state  <= CALC;
          end
        end
        CALC: begin
          // dvd shifts out dividend bits and fills with quotient bits.
          dvd  <= {dvd[W-2:0], st_q};
          prem <= st_rem;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= SIGN;
          end
        end
        SIGN: begin
          // Zero divisor: remainder magnitude is |din0|, so the sign
          // fix-up restores din0 itself; only the quotient is forced.
          if (zero_l) begin
            quot_q <= W'(DBZ_QUOT);
          end else begin
            quot_q <= neg_q ? W'(-dvd) : dvd;
          end
          rem_q <= neg_r ? W'(-prem) : prem;
          dbz_q <= zero_l;
          state <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign quot      = quot_q;
  assign rem       = rem_q;
  assign dbz       = dbz_q;

endmodule

// File: tb/tb_axil_macc_sdiv_32s_32s_32_seq.sv
// Randomized self-checking bench for the sequential signed divider.
// Reference model uses 64-bit C-style division.
module tb_axil_macc_sdiv_32s_32s_32_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] din0 = '0;
  logic [31:0] din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        dbz;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  axil_macc_sdiv_32s_32s_32_seq dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dbz       (dbz)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void model(input  logic [31:0] a,
                                input  logic [31:0] b,
                                output logic [31:0] q,
                                output logic [31:0] r,
                                output logic        z);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
      z = 1'b1;
    end else begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
      z = 1'b0;
    end
  endfunction

  task automatic start(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    din0 = a;
    din1 = b;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    din0 = $urandom;
    din1 = $urandom;
  endtask

  task automatic wait_res(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    logic [31:0] q;
    logic [31:0] r;
    logic z;
    while (!out_valid && n < 60) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    model(a, b, q, r, z);
    chk("latency", 64'(n), 64'd33);
    chk("quot", 64'(quot), 64'(q));
    chk("rem", 64'(rem), 64'(r));
    chk("dbz", 64'(dbz), 64'(z));
  endtask

  task automatic release_res();
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    chk("drain_ov", 64'(out_valid), 64'd0);
    chk("drain_ir", 64'(in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    start(a, b);
    wait_res(a, b);
    release_res();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation timed out");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic z;
    int sel;

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_ir", 64'(in_ready), 64'd1);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_q", 64'(quot), 64'd0);
    chk("rst_r", 64'(rem), 64'd0);
    chk("rst_dbz", 64'(dbz), 64'd0);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;

    run_op(32'd100, 32'd7);
    run_op(-32'sd100, 32'd7);
    run_op(32'd100, -32'sd7);
    run_op(-32'sd100, -32'sd7);
    run_op(32'h8000_0000, 32'hFFFF_FFFF);
    run_op(32'h1234_5678, 32'd0);
    run_op(32'h8000_0000, 32'd0);
    run_op(32'h8000_0000, 32'd1);
    run_op(32'd5, 32'd9);

    // backpressure
    start(32'd1000, -32'sd33);
    wait_res(32'd1000, -32'sd33);
    model(32'd1000, -32'sd33, q, r, z);
    for (int i = 0; i < 10; i++) begin
      @(posedge ap_clk);
      #1;
      chk("bp_ov", 64'(out_valid), 64'd1);
      chk("bp_ir", 64'(in_ready), 64'd0);
      chk("bp_q", 64'(quot), 64'(q));
      chk("bp_r", 64'(rem), 64'(r));
      chk("bp_dbz", 64'(dbz), 64'(z));
    end
    release_res();
    run_op(32'd7, 32'd2);

    // reset during CALC
    start(32'd100, 32'd7);
    repeat (9) begin
      @(posedge ap_clk);
      #1;
    end
    ap_rst_n = 1'b0;
    @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b1;
    chk("mrst_ov", 64'(out_valid), 64'd0);
    chk("mrst_ir", 64'(in_ready), 64'd1);
    chk("mrst_q", 64'(quot), 64'd0);
    chk("mrst_r", 64'(rem), 64'd0);
    chk("mrst_dbz", 64'(dbz), 64'd0);
    run_op(32'd9, 32'd3);

    // randomized
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 9);
      a = $urandom;
      b = $urandom;
      if (sel == 0) begin
        b = 32'd0;
      end else if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end else if (sel == 2) begin
        b = $urandom_range(1, 15);
        if ($urandom_range(0, 1) == 1) b = -b;
      end else if (sel == 3) begin
        b = b >> $urandom_range(1, 30);
      end
      run_op(a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
